dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder at the far end of the MEM1 access interface.
- Accepts one load/store request per transaction: virtual address, rw code, length code, store data.
- Models fixed-latency word-organised storage and applies byte/half/word lane selection and sign/zero extension.
- Returns the load result to the MEM2 stage and drives a pipeline stall while an access is in flight.

Parameters:
- AW, 10, word-address width; storage holds 2**AW 32-bit words.
- LATENCY, 2, cycles from acceptance to resp_valid; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_addr  in  32  byte address
- req_rw  in  2  00 none, 01 read, 10 write, 11 treated as none
- req_length  in  3  000 sbyte, 001 shalf, 010 word, 100 ubyte, 101 uhalf, others as word
- req_wdata  in  32  store data, low-aligned
- req_ready  out  1  responder idle, request can be accepted
- clear  in  1  flush; abort any in-flight access
- stall_out  out  1  freeze upstream pipeline registers
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and misaligned accesses
- resp_misalign  out  1  completed access was misaligned; no storage effect

Behaviour:
- Reset: state IDLE; req_ready=1; stall_out=0; resp_valid=0; resp_rdata=0; resp_misalign=0; counter cleared. Storage contents are not reset.
- Acceptance:
  - fire = req_valid & req_ready & (req_rw==01 | req_rw==10) & ~clear.
  - rw 00 or 11 is ignored.
- Alignment:
  - Half requires addr[0]=0; word requires addr[1:0]=00.
  - On misalign, capture and go to RESP next cycle regardless of LATENCY. resp_misalign=1, rdata=0, no write.
- Addressing:
  - Word index = addr[AW+1:2]; upper bits ignored (aliasing).
  - Lane = addr[1:0].
- States:
  - IDLE: on aligned fire, capture all request fields. Go to RESP if LATENCY==1, else WAIT with cnt=LATENCY-1.
  - WAIT: decrement cnt each cycle; go to RESP when cnt reaches 1.
  - RESP: resp_valid=1 for exactly this cycle; go to IDLE next cycle.
- Storage timing:
  - Store updates storage on the clock edge entering RESP.
  - Load samples storage in that same cycle, so a later request sees earlier stores.
- Store lanes:
  - Byte writes wdata[7:0] to byte lane.
  - Half writes wdata[15:0] to bytes {addr[1],0} and {addr[1],1}.
  - Word writes all 4 bytes.
- Load extension: sbyte/shalf sign-extend; ubyte/uhalf zero-extend.
- resp_rdata and resp_misalign:
  - Registered and valid only while resp_valid=1.
  - Return to 0 in the cycle after RESP.
- req_ready = (state==IDLE).
- stall_out is combinational:
  - high in IDLE on an aligned fire when LATENCY>1, and throughout WAIT;
  - low in RESP and on misaligned fire.
  - The pipeline advances on the resp_valid cycle.
- clear:
  - In IDLE it suppresses acceptance.
  - In WAIT it aborts to IDLE: pending store not written, no resp_valid.
  - In RESP it leaves the already-committed store and the pulse untouched, then returns to IDLE.
- rst mid-operation: same as clear, plus outputs forced to reset values; rst has priority over clear.
- Back-to-back: the earliest next acceptance is the cycle after RESP; throughput is one access per LATENCY+1 cycles.

Optional Feature:
- Macro DMEM_ACCESS_CNT_EN.
- When defined:
  - Adds output ports rd_count (32) and wr_count (32).
  - Each increments by 1 on entering RESP for a non-misaligned read or write, respectively.
  - Wraps modulo 2**32; cleared by rst, not by clear.
- When undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_pkg holds:
  - rw codes (RW_NONE, RW_READ, RW_WRITE);
  - length codes (LEN_SB, LEN_SH, LEN_W, LEN_UB, LEN_UH);
  - state encoding (IDLE, WAIT, RESP).
- One natural sub-module, dmem_lane_align: purely combinational. It takes lane, length, word data and store data, and produces the write byte-enable, the shifted write word, and the extended load data.
- Storage and FSM stay in the top module.

Test Plan:
- LATENCY=2: write word 0xDEADBEEF to 0x100, then read word 0x100. Each access: stall_out high 2 cycles, resp_valid 2 cycles after acceptance. The read returns 0xDEADBEEF.
- After the above: sbyte read of 0x103 returns 0xFFFFFFDE; ubyte returns 0x000000DE; shalf read of 0x100 returns 0xFFFFBEEF; uhalf read of 0x102 returns 0x0000DEAD.
- Byte write 0x5A to 0x101, then word read of 0x100 returns 0xDEAD5AEF. Half write 0x1234 to 0x102, then word read returns 0x12345AEF.
- Half read at 0x101: resp_valid the next cycle, resp_misalign=1, rdata=0, stall_out never high. Word write at 0x102 leaves storage unchanged.
- LATENCY=3: word write 0xCAFEF00D to 0x200, with clear asserted in the 2nd WAIT cycle. Outcome: no resp_valid, req_ready=1 the next cycle, later read of 0x200 returns the old value.
- With DMEM_ACCESS_CNT_EN defined: 3 reads, 2 writes and 1 misaligned read leave rd_count=3, wr_count=2. Asserting rst mid-WAIT zeroes the counters and all outputs.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM1/MEM2 data-memory access path: rw codes,
// length codes, responder state and small decode helpers.
package mem_pkg;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  localparam logic [2:0] LEN_SB = 3'b000;
  localparam logic [2:0] LEN_SH = 3'b001;
  localparam logic [2:0] LEN_W  = 3'b010;
  localparam logic [2:0] LEN_UB = 3'b100;
  localparam logic [2:0] LEN_UH = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Request fields held for the duration of an access.
  typedef struct packed {
    logic [1:0]  rw;
    logic [2:0]  len;
    logic [1:0]  lane;
    logic [31:0] wdata;
    logic        mis;
  } req_t;

  // Unlisted length codes behave as a full word.
  function automatic size_e len_size(logic [2:0] len);
    case (len)
      LEN_SB, LEN_UB: len_size = SZ_B;
      LEN_SH, LEN_UH: len_size = SZ_H;
      default:        len_size = SZ_W;
    endcase
  endfunction

  function automatic logic len_signed(logic [2:0] len);
    len_signed = (len == LEN_SB) || (len == LEN_SH);
  endfunction

  function automatic logic misaligned(logic [2:0] len, logic [1:0] lane);
    case (len_size(len))
      SZ_H:    misaligned = lane[0];
      SZ_W:    misaligned = |lane;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte-enables and replicated store word, plus
// lane extraction with sign/zero extension for loads. Purely combinational.
module dmem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [2:0]  len_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sgn;

  assign sgn = len_signed(len_i);

  always_comb begin
    be_o     = 4'b1111;
    wword_o  = wdata_i;
    rdata_o  = word_i;
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = word_i[{lane_i[1], 4'b0000} +: 16];
    case (len_size(len_i))
      SZ_B: begin
        be_o    = 4'b0001 << lane_i;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sgn & byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sgn & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM1 access interface.
// Optional access counters are enabled with DMEM_ACCESS_CNT_EN.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_rw,
  input  logic [2:0]  req_length,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  input  logic        clear,
  output logic        stall_out,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  req_t          req_q, req_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mis_q, mis_d;

  logic [31:0]   mem_q [2**AW];

  logic          is_idle, rw_ok, fire, req_mis, enter_resp, mem_we;
  logic [AW-1:0] act_idx;
  logic [1:0]    act_lane, act_rw;
  logic [2:0]    act_len;
  logic [31:0]   act_wdata;
  logic          act_mis;
  logic [3:0]    be;
  logic [31:0]   wword, ld_data;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign is_idle = (state_q == IDLE);
  assign rw_ok   = (req_rw == RW_READ) || (req_rw == RW_WRITE);
  assign fire    = req_valid & is_idle & rw_ok & ~clear;
  assign req_mis = misaligned(req_length, req_addr[1:0]);

  // With LATENCY==1 or a misalign the access completes straight from IDLE,
  // so the datapath sees the live request there and the captured copy later.
  assign act_idx   = is_idle ? req_addr[AW+1:2] : idx_q;
  assign act_lane  = is_idle ? req_addr[1:0]    : req_q.lane;
  assign act_len   = is_idle ? req_length       : req_q.len;
  assign act_wdata = is_idle ? req_wdata        : req_q.wdata;
  assign act_rw    = is_idle ? req_rw           : req_q.rw;
  assign act_mis   = is_idle ? req_mis          : req_q.mis;

  dmem_lane_align u_align (
    .lane_i  (act_lane),
    .len_i   (act_len),
    .word_i  (mem_q[act_idx]),
    .wdata_i (act_wdata),
    .be_o    (be),
    .wword_o (wword),
    .rdata_o (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    idx_d      = idx_q;
    rdata_d    = '0;
    mis_d      = 1'b0;
    enter_resp = 1'b0;
    stall_out  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fire) begin
          req_d = '{rw: req_rw, len: req_length, lane: req_addr[1:0],
                    wdata: req_wdata, mis: req_mis};
          idx_d = req_addr[AW+1:2];
          if (req_mis || LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d   = WAIT;
            cnt_d     = 4'(LATENCY - 1);
            stall_out = 1'b1;
          end
        end
      end
      WAIT: begin
        stall_out = 1'b1;
        if (clear) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      mis_d = act_mis;
      if (!act_mis && act_rw == RW_READ) rdata_d = ld_data;
    end
  end

  assign mem_we = enter_resp & ~rst & ~act_mis & (act_rw == RW_WRITE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[act_idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (enter_resp && !act_mis) begin
      if (act_rw == RW_READ)  rd_cnt_q <= rd_cnt_q + 32'd1;
      if (act_rw == RW_WRITE) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

  assign req_ready     = is_idle;
  assign resp_valid    = (state_q == RESP);
  assign resp_rdata    = rdata_q;
  assign resp_misalign = mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=3 instances against a byte-level memory model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst, req_valid, clear, sel;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_rw;
  logic [2:0]  req_length;
  logic [1:0]  rdy, stl, rv, mi;
  logic [1:0][31:0] rdat;
`ifdef DMEM_ACCESS_CNT_EN
  logic [1:0][31:0] rdc, wrc;
`endif

  int passed = 0;
  int total  = 0;

  logic [7:0] mm [2][4096];
  bit         kn [2][4096];
  int         exp_rd [2];
  int         exp_wr [2];

  always #5 clk = ~clk;

  dmem_responder #(.AW(10), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_addr(req_addr),
    .req_rw(req_rw), .req_length(req_length), .req_wdata(req_wdata),
    .req_ready(rdy[0]), .clear(clear), .stall_out(stl[0]), .resp_valid(rv[0]),
    .resp_rdata(rdat[0]), .resp_misalign(mi[0])
`ifdef DMEM_ACCESS_CNT_EN
    , .rd_count(rdc[0]), .wr_count(wrc[0])
`endif
  );

  dmem_responder #(.AW(10), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_addr(req_addr),
    .req_rw(req_rw), .req_length(req_length), .req_wdata(req_wdata),
    .req_ready(rdy[1]), .clear(clear), .stall_out(stl[1]), .resp_valid(rv[1]),
    .resp_rdata(rdat[1]), .resp_misalign(mi[1])
`ifdef DMEM_ACCESS_CNT_EN
    , .rd_count(rdc[1]), .wr_count(wrc[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int nbytes(input logic [2:0] len);
    if (len == 3'd0 || len == 3'd4) return 1;
    if (len == 3'd1 || len == 3'd5) return 2;
    return 4;
  endfunction

  task automatic check_quiet(input int s, input string tag);
    chk({tag, " ready"}, 32'(rdy[s]), 32'd1);
    chk({tag, " stall"}, 32'(stl[s]), 32'd0);
    chk({tag, " valid"}, 32'(rv[s]), 32'd0);
    chk({tag, " rdata"}, rdat[s], 32'd0);
    chk({tag, " misalign"}, 32'(mi[s]), 32'd0);
  endtask

  // One transaction on instance s. abort_at>0 raises clear (or rst) in that
  // WAIT cycle. use_k additionally pins the result to a literal value.
  task automatic access(input int s, input logic [1:0] rw, input logic [2:0] len,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int abort_at, input bit abort_rst,
                        input bit use_k, input logic [31:0] kexp);
    int n = nbytes(len);
    bit mis = (int'(addr[1:0]) % n) != 0;
    int lat = (s == 1) ? 3 : 2;
    int r = mis ? 1 : lat;
    int a = int'(addr[11:0]);
    bit known = 1'b1;
    logic [31:0] v = 32'd0;
    logic [31:0] expd;
    for (int i = 0; i < n; i++) begin
      v = v | (32'(mm[s][a+i]) << (8*i));
      known = known & kn[s][a+i];
    end
    if ((len == 3'd0) && v[7])  v = v | 32'hFFFF_FF00;
    if ((len == 3'd1) && v[15]) v = v | 32'hFFFF_0000;
    expd = (rw == 2'b01 && !mis) ? v : 32'd0;
    if (use_k) expd = kexp;

    @(negedge clk);
    sel = s[0]; req_valid = 1'b1; req_rw = rw; req_length = len;
    req_addr = addr; req_wdata = wd;
    #1;
    chk("accept ready", 32'(rdy[s]), 32'd1);
    chk("accept stall", 32'(stl[s]), 32'(!mis));
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= r; c++) begin
      if (c == abort_at) begin
        if (abort_rst) rst = 1'b1;
        else clear = 1'b1;
        #1;
        chk("abort cycle valid", 32'(rv[s]), 32'd0);
        @(negedge clk);
        clear = 1'b0; rst = 1'b0;
        if (abort_rst) begin
          exp_rd = '{0, 0}; exp_wr = '{0, 0};
        end
        #1;
        check_quiet(s, "after abort");
        return;
      end
      #1;
      chk("resp valid", 32'(rv[s]), 32'(c == r));
      chk("wait stall", 32'(stl[s]), 32'(c < r));
      if (c == r) begin
        chk("misalign flag", 32'(mi[s]), 32'(mis));
        if (known || use_k) chk("rdata", rdat[s], expd);
        if (!mis && rw == 2'b10) begin
          for (int i = 0; i < n; i++) begin
            mm[s][a+i] = wd[8*i +: 8];
            kn[s][a+i] = 1'b1;
          end
        end
        if (!mis && rw == 2'b01) exp_rd[s]++;
        if (!mis && rw == 2'b10) exp_wr[s]++;
      end
      @(negedge clk);
    end
    #1;
    check_quiet(s, "post resp");
  endtask

  // A cycle where the request must be ignored (rw none/11, or clear in IDLE).
  task automatic ignored(input int s, input logic [1:0] rw, input bit clr);
    @(negedge clk);
    sel = s[0]; req_valid = 1'b1; req_rw = rw; req_length = 3'd2;
    req_addr = 32'h100; req_wdata = 32'hFFFF_FFFF; clear = clr;
    #1;
    chk("ignored stall", 32'(stl[s]), 32'd0);
    @(negedge clk);
    req_valid = 1'b0; clear = 1'b0;
    #1;
    check_quiet(s, "ignored");
    @(negedge clk);
    #1;
    chk("ignored later valid", 32'(rv[s]), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; clear = 1'b0; sel = 1'b0;
    req_addr = '0; req_wdata = '0; req_rw = '0; req_length = '0;
    exp_rd = '{0, 0}; exp_wr = '{0, 0};
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4096; i++) begin
        mm[s][i] = 8'h00; kn[s][i] = 1'b0;
      end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet(0, "reset l2");
    check_quiet(1, "reset l3");
    rst = 1'b0;

    // LATENCY=2 directed sequence
    access(0, 2'b10, 3'd2, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0);
    access(0, 2'b01, 3'd2, 32'h100, 0, 0, 0, 1, 32'hDEAD_BEEF);
    access(0, 2'b01, 3'd0, 32'h103, 0, 0, 0, 1, 32'hFFFF_FFDE);
    access(0, 2'b01, 3'd4, 32'h103, 0, 0, 0, 1, 32'h0000_00DE);
    access(0, 2'b01, 3'd1, 32'h100, 0, 0, 0, 1, 32'hFFFF_BEEF);
    access(0, 2'b01, 3'd5, 32'h102, 0, 0, 0, 1, 32'h0000_DEAD);
    access(0, 2'b10, 3'd0, 32'h101, 32'h0000_005A, 0, 0, 0, 0);
    access(0, 2'b01, 3'd2, 32'h100, 0, 0, 0, 1, 32'hDEAD_5AEF);
    access(0, 2'b10, 3'd1, 32'h102, 32'h0000_1234, 0, 0, 0, 0);
    access(0, 2'b01, 3'd2, 32'h100, 0, 0, 0, 1, 32'h1234_5AEF);
    access(0, 2'b01, 3'd1, 32'h101, 0, 0, 0, 1, 32'h0);
    access(0, 2'b10, 3'd2, 32'h102, 32'h0BAD_0BAD, 0, 0, 0, 0);
    ignored(0, 2'b00, 1'b0);
    ignored(0, 2'b11, 1'b0);
    ignored(0, 2'b10, 1'b1);
    access(0, 2'b01, 3'd2, 32'h100, 0, 0, 0, 1, 32'h1234_5AEF);
    access(0, 2'b01, 3'd6, 32'hFFFF_F100, 0, 0, 0, 1, 32'h1234_5AEF);

    // LATENCY=3: clear in the second WAIT cycle drops the store
    access(1, 2'b10, 3'd2, 32'h200, 32'h1111_1111, 0, 0, 0, 0);
    access(1, 2'b10, 3'd2, 32'h200, 32'hCAFE_F00D, 2, 0, 0, 0);
    access(1, 2'b01, 3'd2, 32'h200, 0, 0, 0, 1, 32'h1111_1111);

    // Randomized traffic over a prewritten window with aliased upper bits
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 8; w++)
        access(s, 2'b10, 3'd2, 32'h300 + 32'(4*w), $urandom, 0, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      access(int'($urandom_range(0, 1)), 2'($urandom_range(1, 2)), 3'($urandom_range(0, 7)),
             ($urandom & 32'hFFFF_F000) | 32'h300 | 32'($urandom_range(0, 31)),
             $urandom, 0, 0, 0, 0);
    end

`ifdef DMEM_ACCESS_CNT_EN
    for (int s = 0; s < 2; s++) begin
      chk("rd_count", rdc[s], 32'(exp_rd[s]));
      chk("wr_count", wrc[s], 32'(exp_wr[s]));
    end
`endif

    // rst in the first WAIT cycle of a LATENCY=3 store
    access(1, 2'b10, 3'd2, 32'h300, 32'h7777_7777, 1, 1, 0, 0);
    check_quiet(0, "rst l2");
`ifdef DMEM_ACCESS_CNT_EN
    for (int s = 0; s < 2; s++) begin
      chk("rd_count after rst", rdc[s], 32'd0);
      chk("wr_count after rst", wrc[s], 32'd0);
    end
`endif
    access(1, 2'b01, 3'd2, 32'h300, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
